ex_mem_skid: RTL and testbench

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid.sv | 113 +++++++++++
 tb/tb_ex_mem_skid.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with valid/ready handshake; define EX_MEM_SKID_EN for the two-entry skid buffer with registered ready_o
module ex_mem_skid #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] ALUResult_i,
   input  logic [WIDTH-1:0] RTdata_i,
   input  logic [4:0]       RDaddr_i,
   input  logic [3:0]       ctrl_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] ALUResult_o,
   output logic [WIDTH-1:0] RTdata_o,
   output logic [4:0]       RDaddr_o,
   output logic [3:0]       ctrl_o
);
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
   state_t state, state_n;
   logic [3:0] ctrl_q;
   logic accept, drain;
   assign valid_o = state != EMPTY;
   assign ctrl_o  = valid_o ? ctrl_q : 4'b0000;
   assign accept  = valid_i && ready_o && !flush_i;
   assign drain   = valid_o && ready_i;
`ifdef EX_MEM_SKID_EN
   logic [WIDTH-1:0] skid_alu, skid_rt;
   logic [4:0]       skid_rd;
   logic [3:0]       skid_ctrl;
   logic             ready_q;
   assign ready_o = ready_q;
   // next state: flush wins, otherwise fill/drain the output and skid slots
   always_comb begin
      state_n = state;
      if (flush_i) state_n = EMPTY;
      else if (state == EMPTY) state_n = accept ? FULL : EMPTY;
      else if (state == FULL) state_n = (accept && !drain) ? SKID : (drain && !accept) ? EMPTY : FULL;
      else state_n = drain ? FULL : SKID;
   end
   // state register; ready_o registered from the next state so ready_i never reaches it combinationally
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         ready_q <= state_n != SKID;
      end
   end
   // output slot loads from EX when empty or draining, else from skid; skid catches an accept that cannot drain
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ALUResult_o <= '0;
         RTdata_o    <= '0;
         RDaddr_o    <= '0;
         ctrl_q      <= '0;
         skid_alu    <= '0;
         skid_rt     <= '0;
         skid_rd     <= '0;
         skid_ctrl   <= '0;
      end else begin
         if (accept && (state == EMPTY || drain)) begin
            ALUResult_o <= ALUResult_i;
            RTdata_o    <= RTdata_i;
            RDaddr_o    <= RDaddr_i;
            ctrl_q      <= ctrl_i;
         end else if (state == SKID && drain) begin
            ALUResult_o <= skid_alu;
            RTdata_o    <= skid_rt;
            RDaddr_o    <= skid_rd;
            ctrl_q      <= skid_ctrl;
         end
         if (accept && state == FULL && !drain) begin
            skid_alu  <= ALUResult_i;
            skid_rt   <= RTdata_i;
            skid_rd   <= RDaddr_i;
            skid_ctrl <= ctrl_i;
         end
      end
   end
`else
   assign ready_o = !valid_o || ready_i;
   // next state: single slot fills on accept, empties on drain without refill
   always_comb begin
      state_n = state;
      if (flush_i) state_n = EMPTY;
      else if (accept) state_n = FULL;
      else if (drain) state_n = EMPTY;
   end
   // state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= EMPTY;
      else state <= state_n;
   end
   // output slot loads on every accept
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ALUResult_o <= '0;
         RTdata_o    <= '0;
         RDaddr_o    <= '0;
         ctrl_q      <= '0;
      end else if (accept) begin
         ALUResult_o <= ALUResult_i;
         RTdata_o    <= RTdata_i;
         RDaddr_o    <= RDaddr_i;
         ctrl_q      <= ctrl_i;
      end
   end
`endif
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: queue-model bench for ex_mem_skid with directed vectors and an ordered burst
module tb_ex_mem_skid;
   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
   } ent_t;
   logic clk_i, rst_i, flush_i, valid_i, ready_o, valid_o, ready_i;
   logic [31:0] ALUResult_i, RTdata_i, ALUResult_o, RTdata_o;
   logic [4:0] RDaddr_i, RDaddr_o;
   logic [3:0] ctrl_i, ctrl_o;
   int checks = 0, errors = 0;
   ent_t q[$];
   ent_t log_q[$];
   ent_t sent[100];
   logic burst = 1'b0;
   ex_mem_skid #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .ALUResult_i(ALUResult_i), .RTdata_i(RTdata_i), .RDaddr_i(RDaddr_i), .ctrl_i(ctrl_i),
      .valid_o(valid_o), .ready_i(ready_i), .ALUResult_o(ALUResult_o), .RTdata_o(RTdata_o),
      .RDaddr_o(RDaddr_o), .ctrl_o(ctrl_o)
   );
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // capacity: two entries with the skid buffer, one without
   function automatic logic m_ready();
`ifdef EX_MEM_SKID_EN
      return q.size() < 2;
`else
      return q.size() == 0 || ready_i;
`endif
   endfunction
   function automatic ent_t cur_in();
      return '{ALUResult_i, RTdata_i, RDaddr_i, ctrl_i};
   endfunction
   task automatic mstep(input logic acc, input logic drn, input ent_t e);
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
   endtask
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i || flush_i) q.delete();
      else mstep(valid_i && m_ready(), q.size() != 0 && ready_i, cur_in());
   end
   always @(negedge clk_i) begin
      chk("valid_o", 32'(valid_o), 32'(q.size() != 0));
      chk("ready_o", 32'(ready_o), 32'(m_ready()));
      if (q.size() != 0) begin
         chk("ctrl_o", 32'(ctrl_o), 32'(q[0].ctrl));
         chk("alu_o", ALUResult_o, q[0].alu);
         chk("rt_o", RTdata_o, q[0].rt);
         chk("rd_o", 32'(RDaddr_o), 32'(q[0].rd));
      end else chk("ctrl_bubble", 32'(ctrl_o), 32'd0);
      if (burst && valid_o && ready_i) log_q.push_back('{ALUResult_o, RTdata_o, RDaddr_o, ctrl_o});
   end
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask
   task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] c);
      valid_i = v;
      ALUResult_i = alu;
      RTdata_i = alu ^ 32'hffff0000;
      RDaddr_i = alu[4:0];
      ctrl_i = c;
   endtask
   initial begin
      int k, taken;
      rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
      drive(1'b0, 32'h0, 4'h0);
      #1 rst_i = 1'b0;
      #2;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_ctrl", 32'(ctrl_o), 32'd0);
      chk("rst_alu", ALUResult_o, 32'd0);
      chk("rst_rt", RTdata_o, 32'd0);
      chk("rst_rd", 32'(RDaddr_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      ready_i = 1'b1;
      drive(1'b1, 32'h7, 4'b1000);
      cyc();
      drive(1'b0, 32'h0, 4'h0);
      chk("first_valid", 32'(valid_o), 32'd1);
      chk("first_alu", ALUResult_o, 32'h7);
      chk("first_ctrl", 32'(ctrl_o), 32'h8);
      cyc();
      chk("drained_valid", 32'(valid_o), 32'd0);
      chk("drained_ctrl", 32'(ctrl_o), 32'd0);
      chk("retained_alu", ALUResult_o, 32'h7);
`ifdef EX_MEM_SKID_EN
      ready_i = 1'b0;
      drive(1'b1, 32'h11, 4'b1100);
      cyc();
      chk("a_ready", 32'(ready_o), 32'd1);
      chk("a_alu", ALUResult_o, 32'h11);
      drive(1'b1, 32'h22, 4'b0001);
      cyc();
      chk("b_ready", 32'(ready_o), 32'd0);
      chk("b_hold_alu", ALUResult_o, 32'h11);
      drive(1'b1, 32'h33, 4'b1111);
      cyc();
      chk("c_hold_alu", ALUResult_o, 32'h11);
      chk("c_hold_ctrl", 32'(ctrl_o), 32'hc);
      ready_i = 1'b1;
      drive(1'b0, 32'h0, 4'h0);
      cyc();
      chk("b_out_alu", ALUResult_o, 32'h22);
      chk("b_out_ctrl", 32'(ctrl_o), 32'h1);
      chk("b_out_ready", 32'(ready_o), 32'd1);
      cyc();
      chk("ab_done", 32'(valid_o), 32'd0);
`else
      ready_i = 1'b0;
      drive(1'b1, 32'h77, 4'b1001);
      cyc();
      drive(1'b0, 32'h0, 4'h0);
      #1;
      chk("comb_ready_lo", 32'(ready_o), 32'd0);
      ready_i = 1'b1;
      #1;
      chk("comb_ready_hi", 32'(ready_o), 32'd1);
      cyc();
      chk("g_done", 32'(valid_o), 32'd0);
`endif
      ready_i = 1'b0;
      drive(1'b1, 32'h44, 4'b1010);
      cyc();
      drive(1'b1, 32'h55, 4'b0101);
      cyc();
      chk("pre_flush_ready", 32'(ready_o), 32'd0);
      flush_i = 1'b1;
      drive(1'b1, 32'h66, 4'b1111);
      cyc();
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 4'h0);
      chk("flush_valid", 32'(valid_o), 32'd0);
      chk("flush_ctrl", 32'(ctrl_o), 32'd0);
      chk("flush_ready", 32'(ready_o), 32'd1);
      ready_i = 1'b1;
      repeat (3) cyc();
      chk("flush_stays_empty", 32'(valid_o), 32'd0);
      ready_i = 1'b0;
      drive(1'b1, 32'h88, 4'b1000);
      cyc();
      drive(1'b0, 32'h0, 4'h0);
      chk("h_valid", 32'(valid_o), 32'd1);
      #2 rst_i = 1'b0;
      #1;
      chk("async_valid", 32'(valid_o), 32'd0);
      chk("async_ctrl", 32'(ctrl_o), 32'd0);
      chk("async_alu", ALUResult_o, 32'd0);
      chk("async_ready", 32'(ready_o), 32'd1);
      #2 rst_i = 1'b1;
      ready_i = 1'b1;
      drive(1'b1, 32'h99, 4'b0110);
      cyc();
      drive(1'b0, 32'h0, 4'h0);
      chk("post_rst_valid", 32'(valid_o), 32'd1);
      chk("post_rst_alu", ALUResult_o, 32'h99);
      cyc();
      for (int i = 0; i < 100; i++) sent[i] = '{$urandom, $urandom, 5'($urandom), 4'($urandom)};
      burst = 1'b1;
      k = 0;
      for (int c = 0; c < 1000 && k < 100; c++) begin
         valid_i = 1'b1;
         {ALUResult_i, RTdata_i, RDaddr_i, ctrl_i} = sent[k];
         ready_i = (c % 2) == 0;
         #3 taken = int'(valid_i && m_ready());
         cyc();
         k += taken;
      end
      drive(1'b0, 32'h0, 4'h0);
      chk("burst_accepted", 32'(k), 32'd100);
      ready_i = 1'b1;
      repeat (4) cyc();
      burst = 1'b0;
      chk("burst_count", 32'(log_q.size()), 32'd100);
      for (int i = 0; i < 100 && i < log_q.size(); i++) begin
         chk("burst_alu", log_q[i].alu, sent[i].alu);
         chk("burst_rt", log_q[i].rt, sent[i].rt);
         chk("burst_rd", 32'(log_q[i].rd), 32'(sent[i].rd));
         chk("burst_ctrl", 32'(log_q[i].ctrl), 32'(sent[i].ctrl));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
